irig_frame_decoder: RTL and testbench

IRIG_FRAME_DECODER -- requirements
Module: irig_frame_decoder

---
 rtl/irig_frame_decoder.sv | 249 ++++++++++++++++++++++++
 tb/tb_irig_frame_decoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/irig_frame_decoder.sv
// IRIG-B frame decoder: pulse-width symbol classifier, HUNT/SYNC/TRACK frame sync, BCD time decode.
// Define IRIG_SBS_EN to add the straight-binary-seconds output ts_sbs.
module irig_frame_decoder #(
  parameter int CLK_HZ      = 10000000,
  parameter int LOCK_FRAMES = 2,
  parameter int ERR_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             irigb,
  output logic             pps,
  output logic             ts_valid,
  output logic [5:0]       ts_sec,
  output logic [5:0]       ts_min,
  output logic [4:0]       ts_hour,
  output logic [8:0]       ts_day,
  output logic [6:0]       ts_year,
`ifdef IRIG_SBS_EN
  output logic [16:0]      ts_sbs,
`endif
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);
  localparam int P  = CLK_HZ / 100;
  localparam int CW = $clog2(P * 3 / 2 + 2);
  localparam logic [CW-1:0] T_GL   = CW'(P / 10);
  localparam logic [CW-1:0] T_ZERO = CW'(P * 35 / 100);
  localparam logic [CW-1:0] T_ONE  = CW'(P * 65 / 100);
  localparam logic [CW-1:0] T_MARK = CW'(P * 90 / 100);
  localparam logic [CW-1:0] T_TO   = CW'(P * 3 / 2);

  localparam logic [1:0] SYM_ZERO = 2'd0;
  localparam logic [1:0] SYM_ONE  = 2'd1;
  localparam logic [1:0] SYM_MARK = 2'd2;
  localparam logic [1:0] SYM_ERR  = 2'd3;

  localparam logic [1:0] HUNT  = 2'd0;
  localparam logic [1:0] SYNC  = 2'd1;
  localparam logic [1:0] TRACK = 2'd2;

  function automatic logic [CW-1:0] sat_cnt(input logic [CW-1:0] c);
    return (c >= T_TO) ? c : c + 1'b1;
  endfunction

  function automatic logic [ERR_W-1:0] sat_err(input logic [ERR_W-1:0] e);
    return (&e) ? e : e + 1'b1;
  endfunction

  function automatic logic [9:0] bcd_val(input logic [3:0] h, input logic [3:0] t, input logic [3:0] u);
    return 10'(h) * 10'd100 + 10'(t) * 10'd10 + 10'(u);
  endfunction

  function automatic logic dig_bad(input logic [3:0] d);
    return d > 4'd9;
  endfunction

  logic [2:0]       sync_q, sync_d;
  logic [CW-1:0]    hi_cnt_q, hi_cnt_d, per_cnt_q, per_cnt_d, width;
  logic             armed_q, armed_d, pps_arm_q, pps_arm_d, prev_mark_q, prev_mark_d;
  logic [1:0]       state_q, state_d, sym;
  logic [6:0]       idx_q, idx_d, nidx;
  logic [3:0]       pos_q, pos_d, npos;
  logic [7:0]       good_q, good_d;
  logic [99:0]      frame_q, frame_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             pps_p_q, pps_p_d, pps_q, pps_d, ts_valid_q, ts_valid_d;
  logic [5:0]       ts_sec_q, ts_sec_d, ts_min_q, ts_min_d;
  logic [4:0]       ts_hour_q, ts_hour_d;
  logic [8:0]       ts_day_q, ts_day_d;
  logic [6:0]       ts_year_q, ts_year_d;
  logic             rise, fall, sym_vld, timeout, need_mark, sym_ok, dec_bad, sbs_bad, frame_unused;
  logic [9:0]       sec_b, min_b, hr_b, day_b, yr_b;

  assign rise    = sync_q[1] & ~sync_q[2];
  assign fall    = ~sync_q[1] & sync_q[2];
  assign width   = hi_cnt_q + 1'b1;
  assign sym_vld = fall && (width >= T_GL);
  assign sym     = (width < T_ZERO) ? SYM_ZERO : (width < T_ONE) ? SYM_ONE :
                   (width < T_MARK) ? SYM_MARK : SYM_ERR;
  // Timeout only while the line is settled low, so a long valid high never trips it.
  assign timeout = armed_q && !sync_q[1] && !sync_q[2] && (per_cnt_q >= T_TO);

  assign nidx      = (idx_q == 7'd99) ? 7'd0 : idx_q + 7'd1;
  assign npos      = (pos_q == 4'd9) ? 4'd0 : pos_q + 4'd1;
  assign need_mark = (npos == 4'd9) || (nidx == 7'd0);

  assign sec_b = bcd_val(4'd0, {1'b0, frame_q[8:6]}, frame_q[4:1]);
  assign min_b = bcd_val(4'd0, {1'b0, frame_q[17:15]}, frame_q[13:10]);
  assign hr_b  = bcd_val(4'd0, {2'b0, frame_q[26:25]}, frame_q[23:20]);
  assign day_b = bcd_val({2'b0, frame_q[41:40]}, frame_q[38:35], frame_q[33:30]);
  assign yr_b  = bcd_val(4'd0, frame_q[58:55], frame_q[53:50]);
  assign frame_unused = ^frame_q;

`ifdef IRIG_SBS_EN
  logic [16:0] sbs_b, ts_sbs_q, ts_sbs_d;
  assign sbs_b   = {frame_q[97:90], frame_q[88:80]};
  assign sbs_bad = sbs_b > 17'd86399;
  assign ts_sbs  = ts_sbs_q;
`else
  assign sbs_bad = 1'b0;
`endif

  assign dec_bad = dig_bad(frame_q[4:1]) | dig_bad(frame_q[13:10]) | dig_bad(frame_q[23:20]) |
                   dig_bad(frame_q[33:30]) | dig_bad(frame_q[38:35]) | dig_bad(frame_q[53:50]) |
                   dig_bad(frame_q[58:55]) | (sec_b > 10'd59) | (min_b > 10'd59) | (hr_b > 10'd23) |
                   (day_b == 10'd0) | (day_b > 10'd366) | (yr_b > 10'd99) | sbs_bad;

  always_comb begin
    sync_d      = {sync_q[1:0], irigb};
    hi_cnt_d    = hi_cnt_q;
    per_cnt_d   = sat_cnt(per_cnt_q);
    armed_d     = armed_q;
    pps_arm_d   = pps_arm_q;
    prev_mark_d = prev_mark_q;
    state_d     = state_q;
    idx_d       = idx_q;
    pos_d       = pos_q;
    good_d      = good_q;
    frame_d     = frame_q;
    err_d       = err_q;
    sym_ok      = 1'b0;
    ts_valid_d  = 1'b0;
    // The index-0 rising edge is the one following an accepted index-99 mark.
    pps_p_d     = rise && (state_q == TRACK) && (idx_q == 7'd99) && pps_arm_q;
    pps_d       = pps_p_q;
    if (rise) begin
      hi_cnt_d  = '0;
      pps_arm_d = 1'b0;
    end else if (sync_q[1]) begin
      hi_cnt_d = sat_cnt(hi_cnt_q);
    end
    if (sym_vld) begin
      per_cnt_d = width;
      armed_d   = 1'b1;
    end
    if (timeout) begin
      armed_d     = 1'b0;
      prev_mark_d = 1'b0;
      if (state_q != HUNT) begin
        state_d = HUNT;
        good_d  = '0;
        err_d   = sat_err(err_q);
      end
    end else if (sym_vld) begin
      pps_arm_d = 1'b1;
      if (state_q == HUNT) begin
        prev_mark_d = (sym == SYM_MARK);
        if ((sym == SYM_MARK) && prev_mark_q) begin
          state_d = SYNC;
          idx_d   = '0;
          pos_d   = '0;
          good_d  = '0;
        end
      end else begin
        sym_ok = (sym == SYM_MARK) ? need_mark : ((sym != SYM_ERR) && !need_mark);
        if (!sym_ok) begin
          state_d     = HUNT;
          good_d      = '0;
          prev_mark_d = 1'b0;
          err_d       = sat_err(err_q);
        end else begin
          idx_d = nidx;
          pos_d = npos;
          if (sym != SYM_MARK) frame_d[nidx] = (sym == SYM_ONE);
          if (nidx == 7'd0) begin
            if ((state_q == TRACK) || (good_q + 8'd1 >= 8'(LOCK_FRAMES))) begin
              state_d = TRACK;
              if (dec_bad) err_d = sat_err(err_q);
              else         ts_valid_d = 1'b1;
            end else begin
              good_d = good_q + 8'd1;
            end
          end
        end
      end
    end
    ts_sec_d  = ts_valid_d ? sec_b[5:0] : ts_sec_q;
    ts_min_d  = ts_valid_d ? min_b[5:0] : ts_min_q;
    ts_hour_d = ts_valid_d ? hr_b[4:0]  : ts_hour_q;
    ts_day_d  = ts_valid_d ? day_b[8:0] : ts_day_q;
    ts_year_d = ts_valid_d ? yr_b[6:0]  : ts_year_q;
`ifdef IRIG_SBS_EN
    ts_sbs_d  = ts_valid_d ? sbs_b : ts_sbs_q;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      hi_cnt_q    <= '0;
      per_cnt_q   <= '0;
      armed_q     <= 1'b0;
      pps_arm_q   <= 1'b0;
      prev_mark_q <= 1'b0;
      state_q     <= HUNT;
      idx_q       <= '0;
      pos_q       <= '0;
      good_q      <= '0;
      err_q       <= '0;
      pps_p_q     <= 1'b0;
      pps_q       <= 1'b0;
      ts_valid_q  <= 1'b0;
      ts_sec_q    <= '0;
      ts_min_q    <= '0;
      ts_hour_q   <= '0;
      ts_day_q    <= '0;
      ts_year_q   <= '0;
`ifdef IRIG_SBS_EN
      ts_sbs_q    <= '0;
`endif
    end else begin
      sync_q      <= sync_d;
      hi_cnt_q    <= hi_cnt_d;
      per_cnt_q   <= per_cnt_d;
      armed_q     <= armed_d;
      pps_arm_q   <= pps_arm_d;
      prev_mark_q <= prev_mark_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      pos_q       <= pos_d;
      good_q      <= good_d;
      err_q       <= err_d;
      pps_p_q     <= pps_p_d;
      pps_q       <= pps_d;
      ts_valid_q  <= ts_valid_d;
      ts_sec_q    <= ts_sec_d;
      ts_min_q    <= ts_min_d;
      ts_hour_q   <= ts_hour_d;
      ts_day_q    <= ts_day_d;
      ts_year_q   <= ts_year_d;
`ifdef IRIG_SBS_EN
      ts_sbs_q    <= ts_sbs_d;
`endif
    end
  end

  // Frame bits are pure data and are always fully rewritten before being decoded.
  always_ff @(posedge clk) frame_q <= frame_d;

  assign pps       = pps_q;
  assign ts_valid  = ts_valid_q;
  assign ts_sec    = ts_sec_q;
  assign ts_min    = ts_min_q;
  assign ts_hour   = ts_hour_q;
  assign ts_day    = ts_day_q;
  assign ts_year   = ts_year_q;
  assign locked    = (state_q == TRACK);
  assign err_count = err_q;
endmodule

// File: tb/tb_irig_frame_decoder.sv
// Directed bench for irig_frame_decoder at CLK_HZ=2000 (bit period 20 cycles).
module tb_irig_frame_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        irigb = 1'b0;
  logic        pps, ts_valid, locked;
  logic [5:0]  ts_sec, ts_min;
  logic [4:0]  ts_hour;
  logic [8:0]  ts_day;
  logic [6:0]  ts_year;
  logic [15:0] err_count;
`ifdef IRIG_SBS_EN
  logic [16:0] ts_sbs;
`endif

  int n_chk = 0, n_bad = 0;
  int cyc = 0, nvalid = 0, npps = 0, pps_cyc = 0, ref_cyc = 0;
  logic [99:0] fa, fb, fc, fm75, fd0;

  irig_frame_decoder #(.CLK_HZ(2000), .LOCK_FRAMES(2), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .irigb(irigb), .pps(pps), .ts_valid(ts_valid),
    .ts_sec(ts_sec), .ts_min(ts_min), .ts_hour(ts_hour), .ts_day(ts_day), .ts_year(ts_year),
`ifdef IRIG_SBS_EN
    .ts_sbs(ts_sbs),
`endif
    .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (ts_valid) nvalid++;
    if (pps) begin
      npps++;
      pps_cyc = cyc;
    end
  end

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bit period: high for hi cycles, optional 1-cycle glitch early in the low part.
  task automatic send_sym(input int hi, input bit glitch);
    if (hi == 16) ref_cyc = cyc;
    irigb = 1'b1;
    repeat (hi) tick();
    irigb = 1'b0;
    if (glitch) begin
      repeat (2) tick();
      irigb = 1'b1;
      tick();
      irigb = 1'b0;
      repeat (20 - hi - 3) tick();
    end else begin
      repeat (20 - hi) tick();
    end
  endtask

  // Sends indices 1..99 followed by the closing index-0 mark.
  task automatic send_frame(input logic [99:0] f, input int bad_idx, input bit glitch);
    for (int i = 1; i <= 100; i++) begin
      int k;
      k = i % 100;
      if (k == bad_idx)                 send_sym(4, 1'b0);
      else if ((k % 10 == 9) || k == 0) send_sym(16, 1'b0);
      else                              send_sym(f[k] ? 10 : 4, glitch);
    end
  endtask

  function automatic logic [99:0] mk_frame(input int s, input int m, input int h,
                                           input int d, input int y, input int sbs);
    logic [99:0] f;
    f = '0;
    f[4:1]   = 4'(s % 10);
    f[8:6]   = 3'(s / 10);
    f[13:10] = 4'(m % 10);
    f[17:15] = 3'(m / 10);
    f[23:20] = 4'(h % 10);
    f[26:25] = 2'(h / 10);
    f[33:30] = 4'(d % 10);
    f[38:35] = 4'((d / 10) % 10);
    f[41:40] = 2'(d / 100);
    f[53:50] = 4'(y % 10);
    f[58:55] = 4'(y / 10);
    f[88:80] = 9'(sbs);
    f[97:90] = 8'(sbs >> 9);
    return f;
  endfunction

  initial begin
    fa   = mk_frame(56, 34, 12, 123, 24, 45296);
    fb   = mk_frame(9, 8, 7, 45, 99, 25689);
    fc   = mk_frame(59, 59, 23, 366, 99, 86399);
    fm75 = mk_frame(56, 75, 12, 123, 24, 45296);
    fd0  = mk_frame(56, 34, 12, 0, 24, 45296);

    repeat (3) tick();
    chk("rst_locked", locked, 0);
    chk("rst_err", err_count, 0);
    chk("rst_sec", ts_sec, 0);
    chk("rst_day", ts_day, 0);
    chk("rst_pps", pps, 0);
    chk("rst_valid", ts_valid, 0);
    rst = 1'b0;
    repeat (100) tick();
    chk("idle_err", err_count, 0);

    send_sym(16, 1'b0);
    send_sym(16, 1'b0);
    send_frame(fa, -1, 1'b0);
    chk("f1_locked", locked, 0);
    chk("f1_valid", nvalid, 0);
    send_frame(fa, -1, 1'b0);
    chk("f2_locked", locked, 1);
    chk("f2_valid", nvalid, 1);
    chk("f2_day", ts_day, 123);
    chk("f2_hour", ts_hour, 12);
    chk("f2_min", ts_min, 34);
    chk("f2_sec", ts_sec, 56);
    chk("f2_year", ts_year, 24);
    chk("f2_pps", npps, 0);
    send_frame(fa, -1, 1'b0);
    chk("f3_valid", nvalid, 2);
    chk("f3_pps", npps, 1);
    chk("pps_delay", pps_cyc - ref_cyc, 4);
`ifdef IRIG_SBS_EN
    chk("f3_sbs", ts_sbs, 45296);
`endif

    send_frame(fb, -1, 1'b1);
    chk("glitch_valid", nvalid, 3);
    chk("glitch_err", err_count, 0);
    chk("b_day", ts_day, 45);
    chk("b_hour", ts_hour, 7);
    chk("b_min", ts_min, 8);
    chk("b_sec", ts_sec, 9);
    chk("b_year", ts_year, 99);
    chk("b_pps", npps, 2);
`ifdef IRIG_SBS_EN
    chk("b_sbs", ts_sbs, 25689);
`endif

    send_frame(fa, 19, 1'b0);
    chk("bad19_err", err_count, 1);
    chk("bad19_locked", locked, 0);
    chk("bad19_day", ts_day, 45);
    chk("bad19_valid", nvalid, 3);
    send_frame(fa, -1, 1'b0);
    chk("relock1_locked", locked, 0);
    send_frame(fa, -1, 1'b0);
    chk("relock2_locked", locked, 1);
    chk("relock2_valid", nvalid, 4);
    chk("relock2_day", ts_day, 123);
    chk("relock_pps", npps, 2);

    send_frame(fm75, -1, 1'b0);
    chk("min75_err", err_count, 2);
    chk("min75_locked", locked, 1);
    chk("min75_valid", nvalid, 4);
    chk("min75_min", ts_min, 34);
    chk("min75_pps", npps, 3);

    send_frame(fc, -1, 1'b0);
    chk("max_valid", nvalid, 5);
    chk("max_day", ts_day, 366);
    chk("max_sec", ts_sec, 59);
    chk("max_hour", ts_hour, 23);
    chk("max_err", err_count, 2);

    send_frame(fd0, -1, 1'b0);
    chk("day0_err", err_count, 3);
    chk("day0_valid", nvalid, 5);
    chk("day0_locked", locked, 1);

    repeat (40) tick();
    chk("to_err", err_count, 4);
    chk("to_locked", locked, 0);
    repeat (60) tick();
    chk("to_once", err_count, 4);
    chk("to_hold_day", ts_day, 366);

    send_sym(16, 1'b0);
    send_sym(16, 1'b0);
    repeat (8) send_sym(4, 1'b0);
    rst = 1'b1;
    repeat (3) tick();
    chk("mrst_err", err_count, 0);
    chk("mrst_locked", locked, 0);
    chk("mrst_day", ts_day, 0);
    rst = 1'b0;
    repeat (10) tick();
    send_sym(16, 1'b0);
    send_sym(16, 1'b0);
    send_frame(fa, -1, 1'b0);
    chk("mrst_f1_locked", locked, 0);
    send_frame(fa, -1, 1'b0);
    chk("mrst_f2_locked", locked, 1);
    chk("mrst_f2_sec", ts_sec, 56);
    chk("mrst_f2_valid", nvalid, 6);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
